// File: rtl/scan_ctrl_2_4_pkg.sv
// Shared definitions for the line-scan controller and its mask search helper.
package scan_ctrl_2_4_pkg;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;
endpackage

// File: rtl/scan_ctrl_2_4_mask_next_4.sv
// Finds the lowest set mask bit strictly above cur, wrapping to the lowest set bit overall.
module mask_next_4
  import scan_ctrl_2_4_pkg::*;
(
  input  logic [3:0]       mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);
  always_comb begin
    nxt  = '0;
    wrap = 1'b1;
    none = (mask == 4'b0000);
    // descending scans leave the lowest qualifying index as the final assignment
    for (int i = 3; i >= 0; i--)
      if (mask[i]) nxt = SEL_W'(i);
    for (int i = 3; i >= 0; i--)
      if (mask[i] && (i > int'(cur))) begin
        nxt  = SEL_W'(i);
        wrap = 1'b0;
      end
  end
endmodule

// File: rtl/scan_ctrl_2_4.sv
// Sweep controller driving a 2-to-4 decoder: per-line dwell, optional blank gap, one-hot mirror.
module scan_ctrl_2_4
  import scan_ctrl_2_4_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [3:0]       MASK,
  input  logic             HL,
  output logic [SEL_W-1:0] SEL,
  output logic             EN,
  output logic [3:0]       DIGIT,
  output logic             BUSY,
  output logic             DONE
);
  localparam logic [CNT_W-1:0] DW_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BL_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0] sel_n, cur, nx;
  logic             en_n, done_n, wrap, none;
  logic [3:0]       oh;

  // idle searches from code 3 so the wrap path yields the lowest set bit
  assign cur = (state == ST_IDLE) ? SEL_W'(3) : SEL;

  mask_next_4 u_next (
    .mask (MASK),
    .cur  (cur),
    .nxt  (nx),
    .wrap (wrap),
    .none (none)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      SEL   <= '0;
      EN    <= 1'b0;
      DONE  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      SEL   <= sel_n;
      EN    <= en_n;
      DONE  <= done_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = SEL;
    en_n    = EN;
    done_n  = 1'b0;
    cnt_n   = cnt;
    if (STOP) begin
      state_n = ST_IDLE;
      en_n    = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          en_n = 1'b0;
          if (START && !none) begin
            sel_n   = nx;
            en_n    = 1'b1;
            cnt_n   = '0;
            state_n = ST_DWELL;
          end
        end
        ST_DWELL, ST_BLANK: begin
          if (state == ST_DWELL && cnt == DW_LAST && BLANK > 0) begin
            en_n    = 1'b0;
            cnt_n   = '0;
            state_n = ST_BLANK;
          end else if ((state == ST_DWELL && cnt == DW_LAST) ||
                       (state == ST_BLANK && cnt == BL_LAST)) begin
            // advance step: mask and mode are only looked at here
            cnt_n = '0;
            if (none) begin
              en_n    = 1'b0;
              state_n = ST_IDLE;
            end else if (wrap && MODE) begin
              en_n    = 1'b0;
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              sel_n   = nx;
              en_n    = 1'b1;
              state_n = ST_DWELL;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          en_n    = 1'b0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign oh    = EN ? (4'b0001 << SEL) : 4'b0000;
  assign DIGIT = HL ? oh : ~oh;
endmodule

// File: tb/tb_scan_ctrl_2_4.sv
// Directed bench: dut0 uses DWELL=4/BLANK=1, dut1 uses DWELL=4/BLANK=0, both on shared inputs.
module tb_scan_ctrl_2_4;
  logic       CLK = 1'b0, RST = 1'b1;
  logic       START = 1'b0, STOP = 1'b0, MODE = 1'b0, HL = 1'b0;
  logic [3:0] MASK = 4'b0000;
  logic [1:0] sel0, sel1;
  logic       en0, en1, busy0, busy1, done0, done1;
  logic [3:0] digit0, digit1;
  int         checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  scan_ctrl_2_4 #(.DWELL(4), .BLANK(1), .CNT_W(16)) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE), .MASK(MASK), .HL(HL),
    .SEL(sel0), .EN(en0), .DIGIT(digit0), .BUSY(busy0), .DONE(done0));

  scan_ctrl_2_4 #(.DWELL(4), .BLANK(0), .CNT_W(16)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE), .MASK(MASK), .HL(HL),
    .SEL(sel1), .EN(en1), .DIGIT(digit1), .BUSY(busy1), .DONE(done1));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // pulse START so that it is sampled at the next edge; returns in cycle t0+1
  task automatic go();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic stop_all();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    tick();
  endtask

  initial begin
    logic       e_en;
    logic [1:0] e_sel;
    logic [3:0] e_dig;

    // 1: reset values, then asynchronous reset in the middle of a sweep
    tick(); tick();
    chk("rst_sel", 8'(sel0), 8'd0);
    chk("rst_en", 8'(en0), 8'd0);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_done", 8'(done0), 8'd0);
    chk("rst_digit_hl0", 8'(digit0), 8'hF);
    RST = 1'b0;
    MASK = 4'hF; MODE = 1'b1; HL = 1'b1;
    tick();
    go();
    for (int k = 1; k < 7; k++) tick();
    chk("pre_rst_sel", 8'(sel0), 8'd1);
    chk("pre_rst_en", 8'(en0), 8'd1);
    #2 RST = 1'b1;
    #1;
    chk("arst_sel", 8'(sel0), 8'd0);
    chk("arst_en", 8'(en0), 8'd0);
    chk("arst_busy", 8'(busy0), 8'd0);
    chk("arst_done", 8'(done0), 8'd0);
    chk("arst_digit_hl1", 8'(digit0), 8'h0);
    HL = 1'b0;
    #1;
    chk("arst_digit_hl0", 8'(digit0), 8'hF);
    HL = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    // 2: full single sweep with blanking
    MASK = 4'hF; MODE = 1'b1;
    go();
    for (int k = 1; k <= 22; k++) begin
      e_en  = (k <= 20) && (k % 5 != 0);
      e_sel = (k <= 20) ? 2'((k - 1) / 5) : 2'd3;
      e_dig = e_en ? (4'b0001 << e_sel) : 4'b0000;
      chk($sformatf("sweep_en_c%0d", k), 8'(en0), 8'(e_en));
      chk($sformatf("sweep_sel_c%0d", k), 8'(sel0), 8'(e_sel));
      chk($sformatf("sweep_digit_c%0d", k), 8'(digit0), 8'(e_dig));
      chk($sformatf("sweep_done_c%0d", k), 8'(done0), 8'(k == 21));
      chk($sformatf("sweep_busy_c%0d", k), 8'(busy0), 8'(k <= 20));
      tick();
    end
    stop_all();

    // 3: sparse mask, no blanking (dut1)
    MASK = 4'b1010; MODE = 1'b1;
    go();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("sparse_sel_c%0d", k), 8'(sel1), (k <= 4) ? 8'd1 : 8'd3);
      chk($sformatf("sparse_en_c%0d", k), 8'(en1), 8'(k <= 8));
      chk($sformatf("sparse_done_c%0d", k), 8'(done1), 8'(k == 9));
      tick();
    end
    stop_all();

    // 4: continuous mode, then STOP mid-dwell
    MASK = 4'b0101; MODE = 1'b0;
    go();
    for (int k = 1; k <= 12; k++) begin
      e_en  = (k % 5 != 0);
      e_sel = ((((k - 1) / 5) % 2) == 0) ? 2'd0 : 2'd2;
      chk($sformatf("cont_en_c%0d", k), 8'(en0), 8'(e_en));
      chk($sformatf("cont_sel_c%0d", k), 8'(sel0), 8'(e_sel));
      chk($sformatf("cont_done_c%0d", k), 8'(done0), 8'd0);
      if (k < 12) tick();
    end
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop_en", 8'(en0), 8'd0);
    chk("stop_busy", 8'(busy0), 8'd0);
    chk("stop_sel", 8'(sel0), 8'd0);
    chk("stop_done", 8'(done0), 8'd0);
    tick();
    chk("stop_done_after", 8'(done0), 8'd0);
    chk("stop_busy_after", 8'(busy0), 8'd0);
    stop_all();

    // 5: ignored START cases
    MASK = 4'b0000; MODE = 1'b1;
    go();
    chk("mask0_busy", 8'(busy0), 8'd0);
    chk("mask0_en", 8'(en0), 8'd0);
    tick();
    chk("mask0_done", 8'(done0), 8'd0);
    MASK = 4'hF;
    START = 1'b1; STOP = 1'b1;
    tick();
    START = 1'b0; STOP = 1'b0;
    chk("startstop_busy", 8'(busy0), 8'd0);
    chk("startstop_en", 8'(en0), 8'd0);
    tick();
    go();
    for (int k = 1; k <= 7; k++) begin
      START = (k == 2);
      if (k == 3) begin
        chk("rebusy_sel_c3", 8'(sel0), 8'd0);
        chk("rebusy_en_c3", 8'(en0), 8'd1);
      end
      if (k == 5) chk("rebusy_en_c5", 8'(en0), 8'd0);
      if (k == 7) begin
        chk("rebusy_sel_c7", 8'(sel0), 8'd1);
        chk("rebusy_en_c7", 8'(en0), 8'd1);
      end
      tick();
    end
    START = 1'b0;
    stop_all();

    // 6a: mask cleared during the dwell of line 1 -> idle without DONE
    MASK = 4'hF; MODE = 1'b1;
    go();
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) MASK = 4'b0000;
      if (k == 10) begin
        chk("mclr_busy_c10", 8'(busy0), 8'd1);
        chk("mclr_en_c10", 8'(en0), 8'd0);
      end
      if (k >= 11) begin
        chk($sformatf("mclr_busy_c%0d", k), 8'(busy0), 8'd0);
        chk($sformatf("mclr_done_c%0d", k), 8'(done0), 8'd0);
      end
      tick();
    end
    stop_all();

    // 6b: mask narrowed to line 0 mid-sweep -> wrap ends the single sweep
    MASK = 4'hF; MODE = 1'b1;
    go();
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) MASK = 4'b0001;
      if (k == 11) begin
        chk("mnar_done_c11", 8'(done0), 8'd1);
        chk("mnar_busy_c11", 8'(busy0), 8'd0);
        chk("mnar_sel_c11", 8'(sel0), 8'd1);
      end
      if (k == 12) chk("mnar_done_c12", 8'(done0), 8'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
